// File: rtl/exec_seq.sv
// Execute-stage issue sequencer: holds one decoded op on the execute datapath,
// owns the NZCV status register and hands results to writeback.
module exec_seq #(
    parameter int MC_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [7:0]  in_alu_op,
    input  logic        in_is_cond,
    input  logic [3:0]  in_cond,
    input  logic [3:0]  in_write_flags,
    input  logic        in_swp,
    input  logic        in_mc,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [7:0]  ex_alu_op,
    output logic        ex_is_cond,
    output logic [3:0]  ex_cond,
    output logic [3:0]  ex_write_flags,
    output logic        ex_swp,
    output logic [31:0] ex_st,
    input  logic        ex_n,
    input  logic        ex_z,
    input  logic        ex_c,
    input  logic        ex_v,
    input  logic        ex_cc,
    input  logic [31:0] ex_r1,
    input  logic [31:0] ex_r2,
    input  logic        ex_cres,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_r1,
    output logic [31:0] out_r2,
    output logic        out_cres,
    input  logic        flush,
    input  logic        st_load,
    input  logic [31:0] st_din,
    output logic [31:0] st_q,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [3:0] MC_CNT = 4'(MC_LAT - 1);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        out_valid_q;
    logic        busy_q;
    logic [3:0]  nzcv_q, nzcv_d;
    logic [3:0]  ex_st_q;

    logic [31:0] ex_a_q, ex_b_q;
    logic [7:0]  ex_alu_op_q;
    logic        ex_is_cond_q;
    logic [3:0]  ex_cond_q;
    logic [3:0]  ex_write_flags_q;
    logic        ex_swp_q;

    logic        accept;
    logic        final_exec;
    logic        commit;
    logic        unused_st_din;

    assign unused_st_din = ^st_din[31:4];

    // RESP overlaps the next accept so single-cycle ops sustain one per two cycles.
    assign in_ready   = !flush && (state_q == IDLE || (state_q == RESP && out_ready));
    assign accept     = in_valid && in_ready;
    assign final_exec = (state_q == EXEC) && (cnt_q == 4'd0);
    assign commit     = final_exec && ex_cc && !flush;

    always_comb begin
        // NOTE: default first so every path assigns nzcv_d and no latch is inferred.
        nzcv_d = nzcv_q;
        if (commit) begin
            nzcv_d = {ex_n, ex_z, ex_c, ex_v};
        end else if (st_load) begin
            nzcv_d = st_din[3:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments with an async active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nzcv_q <= 4'd0;
        end else begin
            nzcv_q <= nzcv_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (flush) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (accept) begin
            state_q     <= EXEC;
            cnt_q       <= in_mc ? MC_CNT : 4'd0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            case (state_q)
                EXEC: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q     <= RESP;
                        out_valid_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Operands and the status snapshot only move on accept; flush leaves them in place.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_a_q           <= 32'd0;
            ex_b_q           <= 32'd0;
            ex_alu_op_q      <= 8'd0;
            ex_is_cond_q     <= 1'b0;
            ex_cond_q        <= 4'd0;
            ex_write_flags_q <= 4'd0;
            ex_swp_q         <= 1'b0;
            ex_st_q          <= 4'd0;
        end else if (accept) begin
            ex_a_q           <= in_a;
            ex_b_q           <= in_b;
            ex_alu_op_q      <= in_alu_op;
            ex_is_cond_q     <= in_is_cond;
            ex_cond_q        <= in_cond;
            ex_write_flags_q <= in_write_flags;
            ex_swp_q         <= in_swp;
            ex_st_q          <= nzcv_q;
        end
    end

    assign ex_a           = ex_a_q;
    assign ex_b           = ex_b_q;
    assign ex_alu_op      = ex_alu_op_q;
    assign ex_is_cond     = ex_is_cond_q;
    assign ex_cond        = ex_cond_q;
    assign ex_write_flags = ex_write_flags_q;
    assign ex_swp         = ex_swp_q;
    assign ex_st          = {28'd0, ex_st_q};
    assign st_q           = {28'd0, nzcv_q};
    assign busy           = busy_q;
    assign out_valid      = out_valid_q;
    assign out_r1         = out_valid_q ? ex_r1 : 32'd0;
    assign out_r2         = out_valid_q ? ex_r2 : 32'd0;
    assign out_cres       = out_valid_q & ex_cres;

endmodule

// File: tb/tb_exec_seq.sv
// Bench for exec_seq: a small ALU datapath, a timestamp-based sequencer model
// compared every cycle, and directed scenarios with literal expectations.
module tb_exec_seq;

    localparam int MC_LAT = 3;
    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_SUB = 8'h02;
    localparam logic [7:0] OP_CMP = 8'h03;
    localparam logic [7:0] OP_AND = 8'h04;
    localparam logic [3:0] CC_EQ  = 4'h0;
    localparam logic [3:0] CC_NE  = 4'h1;
    localparam logic [3:0] CC_AL  = 4'hE;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  alu_op;
        logic        is_cond;
        logic [3:0]  cond;
        logic [3:0]  wf;
        logic        swp;
        logic        mc;
    } op_t;

    typedef struct packed {
        logic [31:0] r1;
        logic [31:0] r2;
        logic        cres;
        logic [3:0]  nzcv;
        logic        cc;
    } dp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid, in_ready;
    logic [31:0] in_a, in_b;
    logic [7:0]  in_alu_op;
    logic        in_is_cond;
    logic [3:0]  in_cond, in_write_flags;
    logic        in_swp, in_mc;
    logic [31:0] ex_a, ex_b, ex_st;
    logic [7:0]  ex_alu_op;
    logic        ex_is_cond, ex_swp;
    logic [3:0]  ex_cond, ex_write_flags;
    logic        ex_n, ex_z, ex_c, ex_v, ex_cc;
    logic [31:0] ex_r1, ex_r2;
    logic        ex_cres;
    logic        out_valid, out_ready;
    logic [31:0] out_r1, out_r2;
    logic        out_cres;
    logic        flush, st_load;
    logic [31:0] st_din, st_q;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    exec_seq #(.MC_LAT(MC_LAT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_alu_op(in_alu_op),
        .in_is_cond(in_is_cond), .in_cond(in_cond),
        .in_write_flags(in_write_flags), .in_swp(in_swp), .in_mc(in_mc),
        .ex_a(ex_a), .ex_b(ex_b), .ex_alu_op(ex_alu_op),
        .ex_is_cond(ex_is_cond), .ex_cond(ex_cond),
        .ex_write_flags(ex_write_flags), .ex_swp(ex_swp), .ex_st(ex_st),
        .ex_n(ex_n), .ex_z(ex_z), .ex_c(ex_c), .ex_v(ex_v), .ex_cc(ex_cc),
        .ex_r1(ex_r1), .ex_r2(ex_r2), .ex_cres(ex_cres),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r1(out_r1), .out_r2(out_r2), .out_cres(out_cres),
        .flush(flush), .st_load(st_load), .st_din(st_din), .st_q(st_q),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference ALU: operands optionally swapped, flags merged under the write mask.
    function automatic dp_t dp_eval(input op_t o, input logic [3:0] st);
        dp_t d;
        logic [31:0] x, y, res;
        logic n, z, c, v, pass;
        x = o.swp ? o.b : o.a;
        y = o.swp ? o.a : o.b;
        c = 1'b0;
        v = 1'b0;
        case (o.alu_op)
            OP_ADD: begin
                {c, res} = {1'b0, x} + {1'b0, y};
                v = (x[31] == y[31]) && (res[31] != x[31]);
            end
            OP_SUB, OP_CMP: begin
                res = x - y;
                c = (x >= y);
                v = (x[31] != y[31]) && (res[31] != x[31]);
            end
            default: res = x & y;
        endcase
        n = res[31];
        z = (res == 32'd0);
        case (o.cond)
            CC_EQ:   pass = st[2];
            CC_NE:   pass = !st[2];
            default: pass = 1'b1;
        endcase
        if (!o.is_cond) pass = 1'b1;
        d.r1   = res;
        d.r2   = x ^ y;
        d.cres = pass;
        d.nzcv = {o.wf[3] ? n : st[3], o.wf[2] ? z : st[2],
                  o.wf[1] ? c : st[1], o.wf[0] ? v : st[0]};
        d.cc   = pass && (o.wf != 4'd0);
        return d;
    endfunction

    function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op,
                               input logic ic, input logic [3:0] cc, input logic [3:0] wf,
                               input logic swp, input logic mc);
        op_t o;
        o.a = a; o.b = b; o.alu_op = op; o.is_cond = ic;
        o.cond = cc; o.wf = wf; o.swp = swp; o.mc = mc;
        return o;
    endfunction

    // Datapath stand-in: combinational flags, registered results.
    op_t dut_op, cur_in;
    dp_t dp_now;
    always_comb begin
        dut_op         = '0;
        dut_op.a       = ex_a;
        dut_op.b       = ex_b;
        dut_op.alu_op  = ex_alu_op;
        dut_op.is_cond = ex_is_cond;
        dut_op.cond    = ex_cond;
        dut_op.wf      = ex_write_flags;
        dut_op.swp     = ex_swp;
        cur_in         = mk(in_a, in_b, in_alu_op, in_is_cond, in_cond, in_write_flags, in_swp, in_mc);
    end
    assign dp_now = dp_eval(dut_op, ex_st[3:0]);
    assign {ex_n, ex_z, ex_c, ex_v} = dp_now.nzcv;
    assign ex_cc = dp_now.cc;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_r1 <= 32'd0; ex_r2 <= 32'd0; ex_cres <= 1'b0;
        end else begin
            ex_r1 <= dp_now.r1; ex_r2 <= dp_now.r2; ex_cres <= dp_now.cres;
        end
    end

    // Model: an accepted op at edge E finishes executing at edge E+L and is
    // presented from then until taken; edges are counted in ecnt.
    logic       m_has = 1'b0;
    int         m_resp_edge = 0;
    int         ecnt = 0;
    op_t        m_op = '0;
    logic [3:0] m_snap = 4'd0;
    logic [3:0] m_st = 4'd0;
    int         m_n;
    logic       m_resp, m_exec, m_rdy, m_commit;
    logic [3:0] m_new_st;
    dp_t        m_d;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_has = 1'b0; m_resp_edge = 0; ecnt = 0;
            m_op = '0; m_snap = 4'd0; m_st = 4'd0;
        end else begin
            m_n      = ecnt + 1;
            m_resp   = m_has && (ecnt >= m_resp_edge);
            m_exec   = m_has && !m_resp;
            m_rdy    = !flush && (!m_has || (m_resp && out_ready));
            m_d      = dp_eval(m_op, m_snap);
            m_commit = !flush && m_exec && (m_n == m_resp_edge) && m_d.cc;
            m_new_st = m_commit ? m_d.nzcv : (st_load ? st_din[3:0] : m_st);
            if (flush) begin
                m_has = 1'b0;
            end else if (in_valid && m_rdy) begin
                m_op        = cur_in;
                m_snap      = m_st;
                m_has       = 1'b1;
                m_resp_edge = m_n + (in_mc ? MC_LAT : 1);
            end else if (m_resp && out_ready) begin
                m_has = 1'b0;
            end
            m_st = m_new_st;
            ecnt = m_n;
        end
    end

    logic e_ov, e_rdy;
    dp_t  e_d;
    always @(negedge clk) begin
        if (rst) begin
            e_ov  = m_has && (ecnt >= m_resp_edge);
            e_rdy = !flush && (!m_has || (e_ov && out_ready));
            e_d   = dp_eval(m_op, m_snap);
            check("in_ready", in_ready, e_rdy);
            check("out_valid", out_valid, e_ov);
            check("busy", busy, m_has);
            check("st_q", st_q, {28'd0, m_st});
            check("ex_a", ex_a, m_op.a);
            check("ex_b", ex_b, m_op.b);
            check("ex_ctl", {ex_alu_op, ex_is_cond, ex_cond, ex_write_flags, ex_swp},
                  {m_op.alu_op, m_op.is_cond, m_op.cond, m_op.wf, m_op.swp});
            check("ex_st", ex_st, {28'd0, m_snap});
            check("out_r1", out_r1, e_ov ? e_d.r1 : 32'd0);
            check("out_r2", out_r2, e_ov ? e_d.r2 : 32'd0);
            check("out_cres", out_cres, e_ov ? e_d.cres : 1'b0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input op_t o);
        in_a = o.a; in_b = o.b; in_alu_op = o.alu_op; in_is_cond = o.is_cond;
        in_cond = o.cond; in_write_flags = o.wf; in_swp = o.swp; in_mc = o.mc;
        in_valid = 1'b1;
    endtask

    // Offers an op and returns 1ns after the accepting edge.
    task automatic send(input op_t o, output int t_acc);
        logic got;
        got = 1'b0;
        drive(o);
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
        end
        #1;
        in_valid = 1'b0;
        t_acc = cyc;
        check("send_accept", got, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int   t, t_prev;
    op_t  tbl [4];

    initial begin
        in_valid = 0; in_a = 0; in_b = 0; in_alu_op = 0; in_is_cond = 0; in_cond = 0;
        in_write_flags = 0; in_swp = 0; in_mc = 0;
        out_ready = 1; flush = 0; st_load = 0; st_din = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_st_q", st_q, 32'd0);
        check("rst_ex_a", ex_a, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        step();

        // Single SUB 5-3 with all flags written.
        send(mk(32'd5, 32'd3, OP_SUB, 1'b1, CC_AL, 4'hF, 1'b0, 1'b0), t);
        check("t1_ex_a", ex_a, 32'd5);
        check("t1_st_pre", st_q, 32'd0);
        check("t1_ov_pre", out_valid, 1'b0);
        step();
        check("t1_ov", out_valid, 1'b1);
        check("t1_r1", out_r1, 32'd2);
        check("t1_st", st_q, 32'h2);
        step();
        check("t1_idle", busy, 1'b0);

        // Multi-cycle ADD.
        send(mk(32'd7, 32'd8, OP_ADD, 1'b0, CC_AL, 4'h0, 1'b0, 1'b1), t);
        for (int k = 1; k <= MC_LAT; k++) begin
            check("t2_busy", busy, 1'b1);
            check("t2_rdy", in_ready, 1'b0);
            check("t2_ov", out_valid, 1'b0);
            check("t2_ex_a", ex_a, 32'd7);
            step();
        end
        check("t2_ov_last", out_valid, 1'b1);
        check("t2_r1", out_r1, 32'd15);
        check("t2_busy_last", busy, 1'b1);
        step();

        // Backpressure with a second op pending.
        out_ready = 1'b0;
        send(mk(32'd100, 32'd23, OP_ADD, 1'b0, CC_AL, 4'h0, 1'b0, 1'b0), t);
        drive(mk(32'd40, 32'd2, OP_SUB, 1'b0, CC_AL, 4'h0, 1'b0, 1'b0));
        step();
        for (int k = 0; k < 5; k++) begin
            check("t3_ov", out_valid, 1'b1);
            check("t3_r1", out_r1, 32'd123);
            check("t3_rdy", in_ready, 1'b0);
            check("t3_ex_a", ex_a, 32'd100);
            step();
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("t3_ov_after", out_valid, 1'b0);
        check("t3_ex_a_b", ex_a, 32'd40);
        step();
        check("t3_r1_b", out_r1, 32'd38);
        step();

        // Flag dependency: CMP then EQ-conditional op, Z=1 and then Z=0.
        send(mk(32'd9, 32'd9, OP_CMP, 1'b0, CC_AL, 4'hF, 1'b0, 1'b0), t);
        send(mk(32'd1, 32'd1, OP_ADD, 1'b1, CC_EQ, 4'h0, 1'b0, 1'b0), t);
        check("t4_snap_z1", ex_st, 32'h6);
        step();
        check("t4_cres1", out_cres, 1'b1);
        step();
        send(mk(32'd9, 32'd4, OP_CMP, 1'b0, CC_AL, 4'hF, 1'b0, 1'b0), t);
        send(mk(32'd1, 32'd1, OP_ADD, 1'b1, CC_EQ, 4'h0, 1'b0, 1'b0), t);
        check("t4_snap_z0", ex_st, 32'h2);
        step();
        check("t4_cres0", out_cres, 1'b0);
        step();

        // Flush on the final execute cycle of a flag-writing op.
        send(mk(32'd3, 32'd3, OP_SUB, 1'b0, CC_AL, 4'hF, 1'b0, 1'b0), t);
        flush = 1'b1;
        #1;
        check("t5_rdy_flush", in_ready, 1'b0);
        step();
        flush = 1'b0;
        check("t5_st", st_q, 32'h2);
        check("t5_busy", busy, 1'b0);
        check("t5_ov", out_valid, 1'b0);
        step();
        check("t5_ov2", out_valid, 1'b0);

        // Back-to-back stream: one op every two cycles.
        tbl[0] = mk(32'd3, 32'd10, OP_SUB, 1'b0, CC_AL, 4'h0, 1'b1, 1'b0);
        tbl[1] = mk(32'h7FFF_FFFF, 32'd1, OP_ADD, 1'b0, CC_AL, 4'hF, 1'b0, 1'b0);
        tbl[2] = mk(32'h0000_F0F0, 32'h0000_FF00, OP_AND, 1'b0, CC_AL, 4'h0, 1'b0, 1'b0);
        tbl[3] = mk(32'hFFFF_FFFF, 32'd1, OP_ADD, 1'b1, CC_NE, 4'hF, 1'b0, 1'b0);
        t_prev = 0;
        for (int i = 0; i < 4; i++) begin
            send(tbl[i], t);
            if (i > 0) check("tp_interval", t - t_prev, 2);
            t_prev = t;
        end
        check("tp_st_mid", st_q, 32'h9);
        step();
        check("tp_r1", out_r1, 32'd0);
        check("tp_st", st_q, 32'h6);
        step();

        // Async reset between edges while executing.
        send(mk(32'd1, 32'd2, OP_SUB, 1'b0, CC_AL, 4'hF, 1'b0, 1'b1), t);
        #2;
        rst = 1'b0;
        #1;
        check("ar_busy", busy, 1'b0);
        check("ar_ov", out_valid, 1'b0);
        check("ar_ex_a", ex_a, 32'd0);
        check("ar_ex_st", ex_st, 32'd0);
        check("ar_st", st_q, 32'd0);
        step();
        rst = 1'b1;
        step();

        // Software status write, then commit beating a simultaneous write.
        st_load = 1'b1;
        st_din  = 32'hFFFF_FFFF;
        step();
        st_load = 1'b0;
        check("sl_st", st_q, 32'h0000_000F);
        send(mk(32'd5, 32'd3, OP_SUB, 1'b0, CC_AL, 4'hF, 1'b0, 1'b0), t);
        st_load = 1'b1;
        st_din  = 32'h0000_000C;
        step();
        st_load = 1'b0;
        check("sl_prio", st_q, 32'h2);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_seq.md
# exec_seq

Issue sequencer for the execute stage. Accepts one operation at a time from decode over a valid/ready handshake and holds its operands, ALU op and condition fields stable on the execute datapath for one cycle, or for MC_LAT cycles for multi-cycle ops. Owns the architectural NZCV status register and commits flags from the datapath. Presents results to the memory/writeback side over a second valid/ready handshake.

## Interface
Parameters:
- MC_LAT, default 3: execute cycles for ops flagged in_mc; legal range 2..15.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  decode offers an op
- in_ready  out  1  sequencer accepts; transfer on in_valid && in_ready at a rising edge
- in_a, in_b  in  32  operands
- in_alu_op  in  8  ALU operation
- in_is_cond, in_cond  in  1, 4  conditional flag and condition code
- in_write_flags  in  4  n/z/c/v write mask
- in_swp  in  1  swap operands
- in_mc  in  1  multi-cycle op
- ex_a, ex_b, ex_alu_op, ex_is_cond, ex_cond, ex_write_flags, ex_swp  out  32/32/8/1/4/4/1  registered drive to the execute datapath
- ex_st  out  32  status snapshot to the datapath, latched at accept
- ex_n, ex_z, ex_c, ex_v, ex_cc  in  1 each  datapath flags and flag-write strobe (combinational)
- ex_r1, ex_r2, ex_cres  in  32/32/1  datapath results, registered in the datapath
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- out_r1, out_r2, out_cres  out  32/32/1  results; equal to ex_r1/ex_r2/ex_cres while out_valid=1, 0 otherwise
- flush  in  1  synchronous abort of the in-flight op
- st_load, st_din  in  1, 32  software write of the status register
- st_q  out  32  architectural status register; bits 31:4 always 0
- busy  out  1  state != IDLE

## Operation
- States: IDLE, EXEC, RESP. A 4-bit down-counter cnt is used in EXEC.
- in_ready = (state==IDLE) || (state==RESP && out_ready); forced to 0 while flush=1.
- Accept edge:
  - Latch all in_* fields onto ex_* and latch st_q into ex_st.
  - Load cnt = in_mc ? MC_LAT-1 : 0.
  - Go to EXEC.
- EXEC:
  - ex_* and ex_st are held constant.
  - If cnt != 0: decrement cnt.
  - If cnt == 0, final execute cycle: go to RESP. At that edge, if ex_cc=1, st_q <= {28'b0, ex_n, ex_z, ex_c, ex_v}.
- RESP:
  - out_valid=1. ex_* is held, so the datapath keeps re-registering the same results.
  - On out_ready=1 with in_valid=1: accept the next op, go to EXEC.
  - On out_ready=1 with in_valid=0: go to IDLE.
  - On out_ready=0: stay in RESP.
- ex_st is a snapshot. A flag commit does not alter the ex_st seen by the op that made it, so its ex_cres stays stable during RESP.
- flush=1 at an edge:
  - Go to IDLE and clear out_valid; no accept occurs.
  - If flush coincides with the final EXEC cycle, st_q is not updated.
  - ex_* fields keep their values.
- st_load=1 at an edge: st_q <= {28'b0, st_din[3:0]}. A simultaneous flag commit has priority over st_load.

## Timing
- Reset (rst=0, asynchronous):
  - State IDLE, cnt=0.
  - st_q, ex_*, ex_st all 0.
  - out_valid=0, busy=0.
  - in_ready=1 once rst is released.
- Latency: accept at edge T. EXEC spans cycles T+1..T+L, where L = 1 or MC_LAT. out_valid rises in cycle T+L+1.
- Throughput: one single-cycle op per 2 cycles with out_ready held at 1 (the accept overlaps RESP).
- The flag commit is visible on st_q from cycle T+L+1. An op accepted in RESP snapshots the updated st_q.
- out_valid/out_r* are held unchanged while out_ready=0, for an unbounded number of cycles.

## Test plan
- Reset then single op: in_a=5, in_b=3, SUB, write_flags=4'hF, in_is_cond=1, in_cond=AL, accepted at T -> ex_a=5 in T+1; out_valid in T+2 with out_r1=2; st_q=0 until T+2, then NZCV per datapath (C=1).
- Multi-cycle with MC_LAT=3, in_mc=1 -> busy for cycles T+1..T+4, ex_* constant for cycles T+1..T+3, out_valid first in T+4, in_ready=0 for cycles T+1..T+3.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 pending -> out_r1 stable, no second accept; out_ready=1 -> next op accepted on that edge, out_valid=0 the following cycle.
- Back-to-back flag dependency: CMP setting Z=1, then conditional EQ op -> second op's ex_st[2]=1, out_cres=1; with CMP producing Z=0 -> out_cres=0.
- Flush in the final EXEC cycle of a flag-writing op -> st_q unchanged, state IDLE next cycle, out_valid never asserted.
- Async reset asserted mid-EXEC, between clock edges -> all outputs 0 immediately; st_load=1 with st_din=32'hFFFF_FFFF while IDLE -> st_q=32'h0000_000F.
